// File: rtl/crossbar_arbiter_pkg.sv
// Shared types and constants for the 4x4 crossbar arbiter slice.
// Holds the CPU ownership state encoding and the helper that pulls one target field out of a flattened bus.
package crossbar_pkg;

    localparam int N_CPU = 4;
    localparam int N_MM  = 4;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        OWN  = 2'd2
    } cpu_state_t;

    // Returns the SEL_W-bit field belonging to CPU idx from a flattened per-CPU vector.
    function automatic logic [SEL_W-1:0] get_field(input logic [N_CPU*SEL_W-1:0] vec, input int idx);
        logic [N_CPU*SEL_W-1:0] w_shifted;
        w_shifted = vec >> (SEL_W * idx);
        return w_shifted[SEL_W-1:0];
    endfunction

endpackage

// File: rtl/crossbar_arbiter_rr_arbiter_4.sv
// Four-way round-robin arbiter used once per memory module.
// A grant is issued only when enabled; the pointer then moves just past the winner.
import crossbar_pkg::*;

module rr_arbiter_4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_req,
    input  logic       i_en,
    output logic [3:0] o_grant
);

    logic [1:0] r_ptr;
    logic [1:0] w_cand;
    logic [1:0] w_idx;
    logic       w_found;

    // Scan circularly starting at the pointer; the first requester found wins.
    always_comb begin
        o_grant = '0;
        w_cand  = r_ptr;
        w_idx   = r_ptr;
        w_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w_cand = r_ptr + k[1:0];
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
        if (i_en && w_found) begin
            o_grant[w_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_en && w_found) begin
            r_ptr <= w_idx + 2'd1;
        end
    end

endmodule

// File: rtl/crossbar_arbiter.sv
// Grants the four memory modules of a 4x4 crossbar to the four CPU ports, one owner per module.
// Optional feature: define HOLD_TIMEOUT_EN to revoke a grant after MAX_HOLD owned cycles.
import crossbar_pkg::*;

module crossbar_arbiter #(
    parameter int MAX_HOLD = 15,
    parameter int HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [7:0] req_mm,
    output logic [3:0] grant,
    output logic [7:0] select,
    output logic [3:0] mm_busy
);

    if (MAX_HOLD >= (1 << HOLD_W)) begin : g_bad_hold_w
        $error("crossbar_arbiter: HOLD_W too narrow for MAX_HOLD");
    end

    cpu_state_t                        r_state     [N_CPU];
    cpu_state_t                        w_stateNext [N_CPU];
    logic [N_CPU-1:0]                  r_grant;
    logic [N_CPU-1:0]                  w_grantNext;
    logic [N_CPU-1:0][SEL_W-1:0]       r_select;
    logic [N_CPU-1:0][SEL_W-1:0]       w_selNext;
    logic [N_MM-1:0]                   r_mmBusy;
    logic [N_MM-1:0]                   w_busyNext;
    logic [N_CPU-1:0][SEL_W-1:0]       w_tgt;
    logic [N_MM-1:0][N_CPU-1:0]        w_mmReq;
    logic [N_MM-1:0][N_CPU-1:0]        w_mmGrant;
    logic [N_CPU-1:0]                  w_cpuGrant;
    logic [N_CPU-1:0]                  w_expire;

    assign grant   = r_grant;
    assign select  = r_select;
    assign mm_busy = r_mmBusy;

    // Only waiting CPUs that still assert req compete, each on its current target.
    always_comb begin
        w_tgt   = '0;
        w_mmReq = '0;
        for (int i = 0; i < N_CPU; i++) begin
            w_tgt[i] = get_field(req_mm, i);
            if (r_state[i] == WAIT && req[i]) begin
                w_mmReq[w_tgt[i]][i] = 1'b1;
            end
        end
    end

    for (genvar m = 0; m < N_MM; m++) begin : g_arb
        rr_arbiter_4 u_arb (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_req   (w_mmReq[m]),
            .i_en    (!r_mmBusy[m]),
            .o_grant (w_mmGrant[m])
        );
    end

    always_comb begin
        w_cpuGrant = '0;
        for (int m = 0; m < N_MM; m++) begin
            w_cpuGrant = w_cpuGrant | w_mmGrant[m];
        end
    end

`ifdef HOLD_TIMEOUT_EN
    logic [HOLD_W-1:0] r_hold [N_CPU];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CPU; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CPU; i++) begin
                if (r_state[i] != OWN) begin
                    r_hold[i] <= '0;
                end else begin
                    r_hold[i] <= r_hold[i] + 1'b1;
                end
            end
        end
    end

    // The counter reads MAX_HOLD-1 during the last permitted owned cycle.
    always_comb begin
        w_expire = '0;
        for (int i = 0; i < N_CPU; i++) begin
            w_expire[i] = (r_state[i] == OWN) && (r_hold[i] == HOLD_W'(MAX_HOLD - 1));
        end
    end
`else
    assign w_expire = '0;
`endif

    // Select is captured from the target only on the grant edge, then frozen until release.
    always_comb begin
        w_grantNext = '0;
        w_selNext   = '0;
        w_busyNext  = '0;
        for (int i = 0; i < N_CPU; i++) begin
            w_stateNext[i] = r_state[i];
            case (r_state[i])
                IDLE: begin
                    if (req[i]) w_stateNext[i] = WAIT;
                end
                WAIT: begin
                    if (!req[i])            w_stateNext[i] = IDLE;
                    else if (w_cpuGrant[i]) w_stateNext[i] = OWN;
                end
                OWN: begin
                    if (!req[i])          w_stateNext[i] = IDLE;
                    else if (w_expire[i]) w_stateNext[i] = WAIT;
                end
                default: w_stateNext[i] = IDLE;
            endcase

            w_grantNext[i] = (w_stateNext[i] == OWN);
            if (r_state[i] == WAIT && w_cpuGrant[i]) begin
                w_selNext[i] = w_tgt[i];
            end else if (w_grantNext[i]) begin
                w_selNext[i] = r_select[i];
            end
            if (w_grantNext[i]) begin
                w_busyNext[w_selNext[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CPU; i++) begin
                r_state[i] <= IDLE;
            end
            r_grant  <= '0;
            r_select <= '0;
            r_mmBusy <= '0;
        end else begin
            for (int i = 0; i < N_CPU; i++) begin
                r_state[i] <= w_stateNext[i];
            end
            r_grant  <= w_grantNext;
            r_select <= w_selNext;
            r_mmBusy <= w_busyNext;
        end
    end

endmodule

// File: tb/tb_crossbar_arbiter.sv
// Directed self-checking bench for crossbar_arbiter; outputs sampled 1 time unit after each rising edge.
// Expected values are hand-derived; the hold-timeout scenario follows HOLD_TIMEOUT_EN.
module tb_crossbar_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [7:0] req_mm;
    logic [3:0] grant;
    logic [7:0] select;
    logic [3:0] mm_busy;

    int checks = 0;
    int errors = 0;

    crossbar_arbiter #(.MAX_HOLD(15), .HOLD_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .req_mm  (req_mm),
        .grant   (grant),
        .select  (select),
        .mm_busy (mm_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] reqV, input logic [7:0] mmV);
        req    = reqV;
        req_mm = mmV;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(4'h0, 8'h00);
        #12;
        checkOutput("reset_grant", {4'h0, grant}, 8'h00);
        checkOutput("reset_select", select, 8'h00);
        checkOutput("reset_busy", {4'h0, mm_busy}, 8'h00);
        rst_n = 1'b1;

        // Disjoint targets: every CPU gets its own module one cycle after WAIT.
        applyStimulus(4'hF, 8'hE4);
        tick();
        checkOutput("disjoint_latency", {4'h0, grant}, 8'h00);
        tick();
        checkOutput("disjoint_grant", {4'h0, grant}, 8'h0F);
        checkOutput("disjoint_select", select, 8'hE4);
        checkOutput("disjoint_busy", {4'h0, mm_busy}, 8'h0F);

        // Asynchronous reset while all four own.
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_grant", {4'h0, grant}, 8'h00);
        checkOutput("async_rst_select", select, 8'h00);
        checkOutput("async_rst_busy", {4'h0, mm_busy}, 8'h00);
        applyStimulus(4'h0, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();

        // Contention on MM3 from CPU0..2.
        applyStimulus(4'b0111, 8'h3F);
        tick();
        tick();
        checkOutput("cont_grant0", {4'h0, grant}, 8'h01);
        checkOutput("cont_select0", select, 8'h03);
        checkOutput("cont_busy0", {4'h0, mm_busy}, 8'h08);
        applyStimulus(4'b0110, 8'h3F);
        tick();
        checkOutput("cont_bubble0", {4'h0, grant}, 8'h00);
        checkOutput("cont_bubble0_busy", {4'h0, mm_busy}, 8'h00);
        tick();
        checkOutput("cont_grant1", {4'h0, grant}, 8'h02);
        checkOutput("cont_select1", select, 8'h0C);
        applyStimulus(4'b0100, 8'h3F);
        tick();
        checkOutput("cont_bubble1", {4'h0, grant}, 8'h00);
        tick();
        checkOutput("cont_grant2", {4'h0, grant}, 8'h04);
        checkOutput("cont_select2", select, 8'h30);
        applyStimulus(4'h0, 8'h3F);
        tick();

        // Wrap-around: CPU2 on MM1 leaves ptr[1]=3, so CPU3 beats CPU0.
        applyStimulus(4'b0100, 8'h10);
        tick();
        tick();
        checkOutput("wrap_setup_grant", {4'h0, grant}, 8'h04);
        checkOutput("wrap_setup_busy", {4'h0, mm_busy}, 8'h02);
        applyStimulus(4'h0, 8'h10);
        tick();
        applyStimulus(4'b1001, 8'h41);
        tick();
        tick();
        checkOutput("wrap_grant3", {4'h0, grant}, 8'h08);
        checkOutput("wrap_select3", select, 8'h40);
        applyStimulus(4'b0001, 8'h41);
        tick();
        checkOutput("wrap_bubble", {4'h0, grant}, 8'h00);
        tick();
        checkOutput("wrap_grant0", {4'h0, grant}, 8'h01);
        checkOutput("wrap_select0", select, 8'h01);
        applyStimulus(4'h0, 8'h00);
        tick();

        // Stability: retarget while owning is ignored; withdrawn waiter never sees a grant.
        applyStimulus(4'b0100, 8'h00);
        tick();
        tick();
        checkOutput("stab_grant", {4'h0, grant}, 8'h04);
        applyStimulus(4'b0100, 8'h20);
        tick();
        checkOutput("stab_grant_hold", {4'h0, grant}, 8'h04);
        checkOutput("stab_select", select, 8'h00);
        checkOutput("stab_busy", {4'h0, mm_busy}, 8'h01);
        applyStimulus(4'b0110, 8'h24);
        tick();
        checkOutput("withdraw_wait", {4'h0, grant}, 8'h04);
        applyStimulus(4'b0100, 8'h24);
        tick();
        checkOutput("withdraw_nogrant0", {4'h0, grant}, 8'h04);
        tick();
        checkOutput("withdraw_nogrant1", {4'h0, grant}, 8'h04);
        checkOutput("withdraw_busy", {4'h0, mm_busy}, 8'h01);
        applyStimulus(4'h0, 8'h00);
        tick();

        // Hold behaviour: CPU0 and CPU1 both on MM2, CPU0 wins first.
        applyStimulus(4'b0011, 8'h0A);
        tick();
        tick();
        checkOutput("hold_first_grant", {4'h0, grant}, 8'h01);
        checkOutput("hold_first_select", select, 8'h02);
        for (int c = 2; c <= 15; c++) begin
            tick();
            checkOutput($sformatf("hold_cycle%0d", c), {4'h0, grant}, 8'h01);
        end
        tick();
`ifdef HOLD_TIMEOUT_EN
        checkOutput("hold_revoked", {4'h0, grant}, 8'h00);
        checkOutput("hold_revoked_busy", {4'h0, mm_busy}, 8'h00);
        tick();
        checkOutput("hold_next_owner", {4'h0, grant}, 8'h02);
        checkOutput("hold_next_select", select, 8'h08);
`else
        checkOutput("hold_kept", {4'h0, grant}, 8'h01);
        checkOutput("hold_kept_busy", {4'h0, mm_busy}, 8'h04);
        tick();
        checkOutput("hold_still_kept", {4'h0, grant}, 8'h01);
        checkOutput("hold_still_select", select, 8'h02);
`endif
        applyStimulus(4'h0, 8'h00);
        tick();
        checkOutput("final_idle", {4'h0, grant}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
